// File: rtl/uart_reg_writer.sv
// uart_reg_writer: 8N1 UART receiver that turns every received byte into a
// single register write for the signal generator. The byte is split into
// address = byte[2:0] and data = byte[7:3], presented with a one-cycle
// write_strobe.
//
// Optional build macro UART_PARITY_EN: frames become 8E1. A PARITY state
// samples one extra bit after the data bits. A frame with bad parity (and a
// good stop bit) produces a frame_error pulse instead of a write.
module uart_reg_writer #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       write_strobe,
    output logic [2:0] address,
    output logic [4:0] data,
    output logic       frame_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // START waits half a bit, so every later sample lands mid-bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        EMIT,
        BREAK
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             strobe_reg, strobe_next;
    logic             err_reg, err_next;
    logic [2:0]       addr_reg, addr_next;
    logic [4:0]       data_reg, data_next;
    logic [1:0]       sync_reg;
    logic             rx_s;
    logic             parity_ok;

`ifdef UART_PARITY_EN
    logic             par_bad_reg, par_bad_next;
    assign parity_ok = ~par_bad_reg;
`else
    assign parity_ok = 1'b1;
`endif

    // Two-flop synchronizer; preset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rx_s = sync_reg[1];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            strobe_reg <= 1'b0;
            err_reg    <= 1'b0;
            addr_reg   <= '0;
            data_reg   <= '0;
`ifdef UART_PARITY_EN
            par_bad_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            strobe_reg <= strobe_next;
            err_reg    <= err_next;
            addr_reg   <= addr_next;
            data_reg   <= data_next;
`ifdef UART_PARITY_EN
            par_bad_reg <= par_bad_next;
`endif
        end
    end

    // Next-state logic: frame sequencing, bit sampling and output pulses.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        strobe_next = 1'b0;
        err_next    = 1'b0;
        addr_next   = addr_reg;
        data_next   = data_reg;
`ifdef UART_PARITY_EN
        par_bad_next = par_bad_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next = '0;
                    bit_next = '0;
                    // A line that is high again at mid-start was a glitch.
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    // Even parity: data bits plus parity bit must XOR to 0.
                    par_bad_next = ^{shift_reg, rx_s};
                    state_next   = STOP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        err_next   = 1'b1;
                        state_next = BREAK;
                    end else if (!parity_ok) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        strobe_next = 1'b1;
                        addr_next   = shift_reg[2:0];
                        data_next   = shift_reg[7:3];
                        state_next  = EMIT;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            EMIT: begin
                state_next = IDLE;
            end
            BREAK: begin
                // Hold here while the line stays low so one break gives one error.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign write_strobe = strobe_reg;
    assign frame_error  = err_reg;
    assign address      = addr_reg;
    assign data         = data_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_reg_writer.sv
// Testbench for uart_reg_writer (CLKS_PER_BIT = 16). Directed scenarios plus
// random frames. Every frame sent is scored by a reference model: a queue of
// expected writes and counts of expected writes and errors.
module tb_uart_reg_writer;

    localparam int N = 16;
    localparam int H = N / 2;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN  = 1'b1;
    localparam int LAT_MIN = 10 * N + H + 2;
`else
    localparam bit PAR_EN  = 1'b0;
    localparam int LAT_MIN = 9 * N + H + 2;
`endif
    localparam int LAT_MAX = LAT_MIN + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       write_strobe;
    logic [2:0] address;
    logic [4:0] data;
    logic       frame_error;
    logic       busy;

    uart_reg_writer #(.CLKS_PER_BIT(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .write_strobe (write_strobe),
        .address      (address),
        .data         (data),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model state.
    typedef struct {
        logic [2:0] a;
        logic [4:0] d;
        int         t0;
    } exp_t;
    exp_t exp_q[$];
    int   exp_writes = 0;
    int   exp_errs   = 0;

    // Observed event counters.
    int   cyc           = 0;
    int   strobe_cnt    = 0;
    int   err_cnt       = 0;
    int   extra_strobes = 0;
    logic strobe_prev   = 1'b0;

    always @(posedge clk) cyc++;

    // Monitor: score each write against the model's expected queue.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (strobe_prev) check("busy_after_strobe", busy, 0);
        strobe_prev = write_strobe;
        if (write_strobe) begin
            strobe_cnt++;
            check("strobe_err_overlap", frame_error, 0);
            check("busy_during_strobe", busy, 1);
            if (exp_q.size() == 0) begin
                extra_strobes++;
                $display("write (unexpected) addr=%0d data=0x%02h", address, data);
            end else begin
                e   = exp_q.pop_front();
                lat = cyc - e.t0;
                $display("write addr=%0d data=0x%02h latency=%0d", address, data, lat);
                check("write_addr", address, e.a);
                check("write_data", data, e.d);
                check("latency_in_window", int'(lat >= LAT_MIN && lat <= LAT_MAX), 1);
            end
        end
        if (frame_error) err_cnt++;
    end

    task automatic drive_bits(input logic v, input int cycles);
        rx = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Sends one frame; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        logic good;
        good = stop_bit && !par_flip;
        if (good) begin
            exp_q.push_back('{a: b[2:0], d: b[7:3], t0: cyc});
            exp_writes++;
        end else begin
            exp_errs++;
        end
        drive_bits(1'b0, N);
        for (int i = 0; i < 8; i++) drive_bits(b[i], N);
        if (PAR_EN) drive_bits(^b ^ par_flip, N);
        drive_bits(stop_bit, N);
    endtask

    initial begin
        int   nz;
        int   low_seen;
        int   s0;
        int   e0;
        logic [7:0] b;
        logic stop_bit;
        logic pf;
        int   gap;

        // Reset with the line idle.
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_strobe", write_strobe, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_busy", busy, 0);
        check("rst_address", address, 0);
        check("rst_data", data, 0);
        rst = 1'b0;
        nz = 0;
        repeat (500) begin
            @(negedge clk);
            if (address != 0 || data != 0 || write_strobe || frame_error || busy) nz++;
        end
        check("idle_outputs_quiet", nz, 0);

        // Single good byte.
        s0 = strobe_cnt;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (2 * N) @(negedge clk);
        check("good_byte_strobes", strobe_cnt - s0, 1);
        check("good_byte_errors", err_cnt, exp_errs);
        check("good_byte_address_held", address, 5);
        check("good_byte_data_held", data, 'h14);

        // Back-to-back frames with no idle gap.
        s0 = strobe_cnt;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3B, 1'b1, 1'b0);
        repeat (2 * N) @(negedge clk);
        check("b2b_strobes", strobe_cnt - s0, 3);
        check("b2b_errors", err_cnt, exp_errs);

        // Short glitch on the line is not a start bit.
        s0 = strobe_cnt;
        e0 = err_cnt;
        drive_bits(1'b0, 4);
        drive_bits(1'b1, 2 * N);
        check("glitch_strobes", strobe_cnt - s0, 0);
        check("glitch_errors", err_cnt - e0, 0);
        check("glitch_busy", busy, 0);

        // Reset partway through bit 4 of a frame abandons it.
        s0 = strobe_cnt;
        drive_bits(1'b0, 5 * N + 3);
        rx  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_address", address, 0);
        check("midrst_data", data, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (12 * N) @(negedge clk);
        check("midrst_strobes", strobe_cnt - s0, 0);
        send_frame(8'h12, 1'b1, 1'b0);
        repeat (2 * N) @(negedge clk);
        check("after_rst_strobes", strobe_cnt - s0, 1);
        check("after_rst_address", address, 2);
        check("after_rst_data", data, 2);

        // Bad stop bit followed by a held-low line.
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        low_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (!busy) low_seen++;
        end
        check("break_busy_held", low_seen, 0);
        drive_bits(1'b1, N);
        check("break_busy_released", busy, 0);
        check("break_errors", err_cnt - e0, 1);
        check("break_strobes", strobe_cnt - s0, 0);
        check("break_address_kept", address, 2);
        check("break_data_kept", data, 2);

`ifdef UART_PARITY_EN
        // Bad parity with a good stop bit: error, no write.
        s0 = strobe_cnt;
        e0 = err_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (2 * N) @(negedge clk);
        check("parity_errors", err_cnt - e0, 1);
        check("parity_strobes", strobe_cnt - s0, 0);
        check("parity_address_kept", address, 2);
`endif

        // Random frames with random gaps and occasional bad framing.
        for (int k = 0; k < 40; k++) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 9) != 0);
            pf       = PAR_EN && ($urandom_range(0, 7) == 0);
            send_frame(b, stop_bit, pf);
            rx  = 1'b1;
            gap = stop_bit ? int'($urandom_range(0, 3 * N)) : int'($urandom_range(4, 3 * N));
            repeat (gap) @(negedge clk);
        end
        repeat (3 * N) @(negedge clk);

        check("total_strobes", strobe_cnt, exp_writes);
        check("total_errors", err_cnt, exp_errs);
        check("extra_strobes", extra_strobes, 0);
        check("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_reg_writer.md
Name: uart_reg_writer

Overview:
- Serial front end sitting directly upstream of the signal generator.
- Receives 8N1 UART bytes on a single pin, with 1 byte = 1 register write.
- Each byte is split into address = byte[2:0] and data = byte[7:3], then emitted with a one-cycle write_strobe on the generator's write port (address 3 bits, data 5 bits).
- Lets the generator be programmed from one pin instead of a parallel bus plus strobe.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200). Legal range 8..1023. Counter width = clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous UART line; idles high
- write_strobe  output  1  one-cycle pulse; address and data are valid while it is high
- address  output  3  register address, byte[2:0]
- data  output  5  register data, byte[7:3]
- frame_error  output  1  one-cycle pulse on a bad stop bit (or bad parity, see Optional Feature)
- busy  output  1  high whenever FSM is not in IDLE

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE; synchronizer flops preset to 1; bit and clock counters cleared.
  - Outputs: write_strobe=0, address=0, data=0, frame_error=0, busy=0.
  - Reset mid-frame abandons the byte; no strobe is issued.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s only.
- IDLE: on rx_s==0, clear the clock counter and go to START.
- START: count to CLKS_PER_BIT/2 (integer divide), then sample rx_s.
  - rx_s==1 → glitch: back to IDLE, no error.
  - rx_s==0 → go to DATA with clock counter cleared.
- DATA: sample rx_s each time the counter reaches CLKS_PER_BIT-1 (mid-bit).
  - Shift in LSB first; 8 samples.
  - After the 8th sample, go to STOP (or PARITY when enabled).
- STOP: sample rx_s at mid-bit.
  - rx_s==1 → go to EMIT.
  - rx_s==0 → pulse frame_error for one cycle, go to BREAK.
- EMIT: lasts exactly one cycle.
  - address<=byte[2:0], data<=byte[7:3], write_strobe=1 for that one registered cycle.
  - Then return to IDLE. A new start bit can be detected on the very next cycle.
- BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line from producing repeated errors.
- Outputs are registered. address and data hold their last written value until the next EMIT. They are never changed by errors.
- Latency: write_strobe rises between 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 2 and +4 cycles after the rx falling edge.
- write_strobe and frame_error are never high together; each is high at most once per frame.
- rx is ignored outside IDLE and BREAK except at sample points. The data path has no back-pressure: the generator accepts a write every cycle.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state between DATA and STOP samples one extra bit at mid-bit.
  - If the XOR of the 8 data bits and the parity bit is 1, still wait through STOP.
  - Then pulse frame_error instead of write_strobe and go to IDLE (or to BREAK if the stop bit was 0).
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state; frame is 8N1 exactly as above.

Test Plan:
- Reset: CLKS_PER_BIT=16, hold rst=1 for 3 cycles, rx=1 → all outputs 0, busy=0; address/data remain 0 for 500 idle cycles.
- Good byte: send 0xA5 (8N1) → exactly one write_strobe pulse with address=3'd5, data=5'h14, within the latency window above; frame_error stays 0; busy drops the cycle after the strobe.
- Back-to-back: send 0x00, 0xFF, 0x3B with zero idle gap → three strobes in order: (0,0x00), (7,0x1F), (3,0x07); no error.
- Glitch and mid-frame reset:
  - Pulse rx low for 4 cycles (< CLKS_PER_BIT/2) → no strobe, no error, busy returns to 0.
  - Assert rst at bit 4 of a frame → no strobe; the next clean byte 0x12 is received as address=2, data=0x02.
- Framing error: send 0x5A with stop bit 0, then hold rx low for 40 cycles → one frame_error pulse, no strobe, address/data unchanged, busy stays high until rx returns high.
- UART_PARITY_EN: 0xA5 with parity 0 → strobe (5, 0x14); 0xA5 with parity 1 → one frame_error pulse, no strobe.
